// File: rtl/mem_io_subsystem_pkg.sv
// Shared constants for the memory/I-O subsystem: I/O window offsets and loader states.
package mem_io_subsystem_pkg;

  localparam logic [1:0] IO_OUT_OFS    = 2'd0;
  localparam logic [1:0] IO_IN_OFS     = 2'd1;
  localparam logic [1:0] IO_CYCLES_OFS = 2'd2;
  localparam logic [1:0] IO_ZERO_OFS   = 2'd3;

  // Loader state encoding; RUN is terminal until reset.
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/mem_io_subsystem_ram.sv
// Single write port, single registered read port RAM; a same-edge read returns the old word.
module mem_io_subsystem_ram #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Storage is deliberately left unreset so an image survives a reset pulse.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_io_subsystem.sv
// CPU-facing RAM with a 4-location I/O window at IO_BASE and a boot loader that
// fills RAM from a valid/ready byte stream while holding the CPU in reset.
module mem_io_subsystem
  import mem_io_subsystem_pkg::*;
#(
  parameter int                   ADDR_BITS = 8,
  parameter int                   DATA_BITS = 8,
  parameter logic [ADDR_BITS-1:0] IO_BASE   = 8'hFC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 cpu_hold,
  input  logic [DATA_BITS-1:0] io_in,
  output logic [DATA_BITS-1:0] io_out,
  output logic                 io_out_strobe
);

  // Loader handshake: a byte transfers on any rising edge where load_valid and
  // load_ready are both 1 while in LOAD; load_ready is registered and never
  // depends combinationally on load_valid.

  localparam logic [ADDR_BITS-1:0] LAST_LOAD_PTR = IO_BASE - ADDR_BITS'(1);

  logic [0:0]           state;
  logic [ADDR_BITS-1:0] load_ptr;
  logic                 in_run;
  logic                 load_accept;
  logic                 load_done;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic                 rd_is_io;
  logic                 wr_is_io;
  logic [1:0]           rd_ofs;
  logic [1:0]           wr_ofs;
  logic                 io_out_we;

  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [DATA_BITS-1:0] ram_wdata;
  logic                 ram_re;
  logic [DATA_BITS-1:0] ram_rdata;

  logic [DATA_BITS-1:0] io_in_meta;
  logic [DATA_BITS-1:0] io_in_sync;
  logic [DATA_BITS-1:0] cycle_cnt;
  logic [DATA_BITS-1:0] io_rd_next;
  logic [DATA_BITS-1:0] io_rd_q;
  logic                 rd_from_ram;

  assign in_run      = (state == RUN);
  assign load_accept = !in_run && load_valid && load_ready;
  assign load_done   = load_accept && (load_last || (load_ptr == LAST_LOAD_PTR));

  assign cpu_rd   = in_run && rd_en;
  assign cpu_wr   = in_run && wr_en;
  assign rd_is_io = (rd_addr >= IO_BASE);
  assign wr_is_io = (wr_addr >= IO_BASE);
  // IO_BASE is 4-aligned, so the low two address bits select the register.
  assign rd_ofs    = rd_addr[1:0];
  assign wr_ofs    = wr_addr[1:0];
  assign io_out_we = cpu_wr && wr_is_io && (wr_ofs == IO_OUT_OFS);

  always_comb begin
    ram_we    = load_accept;
    ram_waddr = load_ptr;
    ram_wdata = load_data;
    if (in_run) begin
      ram_we    = cpu_wr && !wr_is_io;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
    end
  end

  assign ram_re = cpu_rd && !rd_is_io;

  mem_io_subsystem_ram #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      load_ptr   <= '0;
    end else if (!in_run) begin
      if (load_accept) begin
        load_ptr <= load_ptr + ADDR_BITS'(1);
      end
      if (load_done) begin
        state      <= RUN;
        load_ready <= 1'b0;
        cpu_hold   <= 1'b0;
      end else begin
        load_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_in_meta <= '0;
      io_in_sync <= '0;
    end else begin
      io_in_meta <= io_in;
      io_in_sync <= io_in_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (in_run) begin
      cycle_cnt <= cycle_cnt + DATA_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out        <= '0;
      io_out_strobe <= 1'b0;
    end else begin
      io_out_strobe <= io_out_we;
      if (io_out_we) begin
        io_out <= wr_data;
      end
    end
  end

  always_comb begin
    io_rd_next = '0;
    case (rd_ofs)
      IO_OUT_OFS:    io_rd_next = io_out;
      IO_IN_OFS:     io_rd_next = io_in_sync;
      IO_CYCLES_OFS: io_rd_next = cycle_cnt;
      default:       io_rd_next = '0;
    endcase
  end

  // I/O reads are captured at the same edge as the RAM read, so both sources
  // share the one-cycle latency and hold together when rd_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_from_ram <= 1'b0;
      io_rd_q     <= '0;
    end else if (cpu_rd) begin
      rd_from_ram <= !rd_is_io;
      io_rd_q     <= io_rd_next;
    end
  end

  assign rd_data = rd_from_ram ? ram_rdata : io_rd_q;

endmodule
